// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared widths, die limits and roll FSM states for dice_roller
package dice_pkg;
  localparam int DIE_W = 3;
  localparam int SUM_W = 4;
  localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

  typedef enum logic {IDLE, ROLLING} roll_state_t;
endpackage

// File: rtl/dice_roller_if.sv
// rtl/dice_roller_if.sv - button/roll-enable inputs and latched dice result outputs
interface dice_roller_if;
  import dice_pkg::*;

  logic             btn_raw;
  logic             roll_en;
  logic [DIE_W-1:0] die_a;
  logic [DIE_W-1:0] die_b;
  logic [SUM_W-1:0] sum;
  logic             roll_done;
  logic             rolling;

  modport master (output btn_raw, roll_en, input die_a, die_b, sum, roll_done, rolling);
  modport slave  (input btn_raw, roll_en, output die_a, die_b, sum, roll_done, rolling);
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer plus stable-count debouncer with edge pulses
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db,
  output logic db_rise,
  output logic db_fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [1:0]    warm;
  logic          armed;
  logic          db_q;
  logic [CW-1:0] cnt;
  logic          btn_sync;
  logic          differ;

  assign btn_sync = sync[1];
  // A button held through reset stays ignored until a synchronized low is seen
  // once the synchronizer has refilled.
  assign differ   = armed & (btn_sync ^ btn_db);
  assign db_rise  = btn_db & ~db_q;
  assign db_fall  = ~btn_db & db_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      warm   <= '0;
      armed  <= 1'b0;
      db_q   <= 1'b0;
      btn_db <= 1'b0;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], btn_raw};
      warm <= {warm[0], 1'b1};
      db_q <= btn_db;
      if (warm[1] && !btn_sync)
        armed <= 1'b1;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_db <= btn_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - free-running dice counters latched on each accepted press-and-release
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  dice_roller_if.slave bus
);
  logic             btn_db;
  logic             db_rise;
  logic             db_fall;
  logic [DIE_W-1:0] cnt_a;
  logic [DIE_W-1:0] cnt_b;
  roll_state_t      state;
  roll_state_t      state_next;
  logic             latch;
  logic [DIE_W-1:0] die_a_q;
  logic [DIE_W-1:0] die_b_q;
  logic [SUM_W-1:0] sum_q;
  logic             done_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_raw),
    .btn_db  (btn_db),
    .db_rise (db_rise),
    .db_fall (db_fall)
  );

  // cnt_b advances only on cnt_a wrap, walking all 36 pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a <= DIE_MIN;
      cnt_b <= DIE_MIN;
    end else if (cnt_a == DIE_MAX) begin
      cnt_a <= DIE_MIN;
      cnt_b <= (cnt_b == DIE_MAX) ? DIE_MIN : cnt_b + 1'b1;
    end else begin
      cnt_a <= cnt_a + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (db_rise && bus.roll_en)
          state_next = ROLLING;
      end
      ROLLING: begin
        if (db_fall) begin
          latch      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      die_a_q <= '0;
      die_b_q <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= latch;
      if (latch) begin
        die_a_q <= cnt_a;
        die_b_q <= cnt_b;
        sum_q   <= SUM_W'(cnt_a) + SUM_W'(cnt_b);
      end
    end
  end

  assign bus.die_a     = die_a_q;
  assign bus.die_b     = die_b_q;
  assign bus.sum       = sum_q;
  assign bus.roll_done = done_q;
  assign bus.rolling   = (state == ROLLING);
endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - scoreboard bench for dice_roller with DEBOUNCE_CYCLES=4
module tb_dice_roller;
  import dice_pkg::*;

  localparam int D = 4;

  typedef struct {
    int a;
    int b;
    int s;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dice_roller_if bus ();

  dice_roller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 0;
  int   last_a = 0;
  int   last_b = 0;
  int   last_s = 0;

  task automatic expect_eq(string tag, int obs, int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int die_a_at(int f);
    return (f % 6) + 1;
  endfunction

  function automatic int die_b_at(int f);
    return ((f / 6) % 6) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    expect_eq("rst_die_a", bus.die_a, 0);
    expect_eq("rst_die_b", bus.die_b, 0);
    expect_eq("rst_sum", bus.sum, 0);
    expect_eq("rst_roll_done", bus.roll_done, 0);
    expect_eq("rst_rolling", bus.rolling, 0);
    expect_eq("rst_cnt_a", dut.cnt_a, 1);
    expect_eq("rst_cnt_b", dut.cnt_b, 1);
    reset = 1'b0;
    k = 0;
    last_a = 0;
    last_b = 0;
    last_s = 0;
  endtask

  // Release at cycle r gives db_fall at r+D+2 and roll_done at r+D+3.
  task automatic roll(int extra, bit en, int target);
    int r;
    int f;
    exp_t e;
    bus.roll_en = en;
    bus.btn_raw = 1'b1;
    repeat (D + 3) tick();
    bus.roll_en = 1'b1;
    repeat (extra) tick();
    while (target >= 0 && ((k + D + 2) % 36) != target) tick();
    expect_eq("rolling_before_release", bus.rolling, int'(en));
    r = k;
    f = r + D + 2;
    bus.btn_raw = 1'b0;
    if (en) begin
      e.a = die_a_at(f);
      e.b = die_b_at(f);
      e.s = e.a + e.b;
      e.cyc = r + D + 3;
      sb.push_back(e);
      last_a = e.a;
      last_b = e.b;
      last_s = e.s;
    end
    repeat (D + 4) tick();
    expect_eq("pending_rolls", sb.size(), 0);
    expect_eq("held_die_a", bus.die_a, last_a);
    expect_eq("held_sum", bus.sum, last_s);
    expect_eq("rolling_after", bus.rolling, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.roll_done === 1'b1) begin
      if (sb.size() == 0) begin
        expect_eq("spurious_roll_done", 1, 0);
      end else begin
        got = sb.pop_front();
        expect_eq("die_a", bus.die_a, got.a);
        expect_eq("die_b", bus.die_b, got.b);
        expect_eq("sum", bus.sum, got.s);
        expect_eq("done_cycle", k, got.cyc);
        expect_eq("rolling_at_done", bus.rolling, 0);
        expect_eq("die_a_range", int'(bus.die_a >= 1 && bus.die_a <= 6), 1);
        expect_eq("die_b_range", int'(bus.die_b >= 1 && bus.die_b <= 6), 1);
      end
    end
  end

  initial begin
    bus.btn_raw = 1'b0;
    bus.roll_en = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (5) tick();

    bus.roll_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.btn_raw = ((i / 2) % 2) == 0;
      tick();
      expect_eq("bounce_btn_db", dut.u_debouncer.btn_db, 0);
      expect_eq("bounce_rolling", bus.rolling, 0);
    end
    bus.btn_raw = 1'b0;
    repeat (D + 4) tick();
    expect_eq("bounce_die_a", bus.die_a, 0);

    roll(0, 1'b1, 7);
    expect_eq("det7_die_a", bus.die_a, 2);
    expect_eq("det7_die_b", bus.die_b, 2);
    expect_eq("det7_sum", bus.sum, 4);
    roll(0, 1'b1, 35);
    expect_eq("det35_die_a", bus.die_a, 6);
    expect_eq("det35_die_b", bus.die_b, 6);
    expect_eq("det35_sum", bus.sum, 12);

    roll(3, 1'b0, -1);
    expect_eq("gated_die_b", bus.die_b, 6);
    expect_eq("gated_sum", bus.sum, 12);

    bus.roll_en = 1'b1;
    bus.btn_raw = 1'b1;
    repeat (D + 4) tick();
    expect_eq("midroll_rolling", bus.rolling, 1);
    do_reset();
    repeat (2) tick();
    bus.btn_raw = 1'b0;
    repeat (D + 6) tick();
    expect_eq("midroll_die_a", bus.die_a, 0);
    expect_eq("midroll_sum", bus.sum, 0);
    expect_eq("midroll_rolling_after", bus.rolling, 0);
    expect_eq("midroll_btn_db", dut.u_debouncer.btn_db, 0);
    roll(1, 1'b1, -1);

    for (int n = 0; n < 2000; n++) begin
      roll($urandom_range(0, 7), $urandom_range(0, 3) != 0, -1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
